// File: rtl/register_64_if.sv
// register_64_if: write data, read/write enables and read data of one register_64
interface register_64_if #(parameter int WIDTH = 64);
  logic [WIDTH-1:0] in;
  logic             Read;
  logic             En;
  logic [WIDTH-1:0] out;
  modport master (output in, Read, En, input out);
  modport slave  (input in, Read, En, output out);
endinterface

// File: rtl/register_64.sv
// register_64: parallel-load register with gated read port; define REGISTER_64_BYPASS_EN for write-through reads
module register_64 #(
  parameter int               WIDTH       = 64,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter bit               TRISTATE    = 1
) (
  input logic          Clk,
  input logic          Rst,
  register_64_if.slave bus
);
  logic [WIDTH-1:0] q_q, q_d, rd;
  always_comb q_d = bus.En ? bus.in : q_q;
  always_ff @(posedge Clk)
    if (Rst) q_q <= RESET_VALUE;
    else     q_q <= q_d;
`ifdef REGISTER_64_BYPASS_EN
  always_comb rd = (bus.En && !Rst) ? bus.in : q_q;
`else
  always_comb rd = q_q;
`endif
  // Undriven read data lets several instances share one bus; TRISTATE=0 parks it at zero instead
  if (TRISTATE) begin : g_tri
    assign bus.out = bus.Read ? rd : 'z;
  end else begin : g_zero
    assign bus.out = bus.Read ? rd : '0;
  end
endmodule

// File: tb/tb_register_64.sv
// tb_register_64: directed vectors for register_64 in tristate and zero-parking builds
module tb_register_64;
  logic clk = 0;
  logic rst = 0;
  int checks = 0, failures = 0;
  register_64_if #(.WIDTH(64)) b0 ();
  register_64_if #(.WIDTH(64)) b1 ();
  register_64 #(.WIDTH(64), .TRISTATE(0)) dut0 (.Clk(clk), .Rst(rst), .bus(b0.slave));
  register_64 #(.WIDTH(64), .TRISTATE(1)) dut1 (.Clk(clk), .Rst(rst), .bus(b1.slave));
  always #5 clk = ~clk;
  typedef struct {
    logic        r;
    logic        e;
    logic        rd;
    logic [63:0] d;
    logic [63:0] exp;
    string       name;
  } vec_t;
  vec_t v [10];
  task automatic drive(input logic r, input logic e, input logic rd, input logic [63:0] d);
    rst = r; b0.En = e; b1.En = e; b0.Read = rd; b1.Read = rd; b0.in = d; b1.in = d;
  endtask
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    v[0] = '{1, 0, 1, 64'h0,                   64'h0,                   "reset"};
    v[1] = '{0, 0, 1, 64'h1111,                64'h0,                   "hold1"};
    v[2] = '{0, 0, 1, 64'h2222,                64'h0,                   "hold2"};
    v[3] = '{0, 0, 1, 64'h3333,                64'h0,                   "hold3"};
    v[4] = '{0, 1, 1, 64'h59,                  64'h59,                  "write59"};
    v[5] = '{0, 0, 1, 64'h25,                  64'h59,                  "noen25"};
    v[6] = '{0, 1, 1, 64'h25,                  64'h25,                  "write25"};
    v[7] = '{1, 1, 1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0,                   "rst_wins"};
    v[8] = '{0, 1, 0, 64'hA5A5_A5A5_A5A5_A5A5, 64'h0,                   "write_noread"};
    v[9] = '{0, 0, 1, 64'h0,                   64'hA5A5_A5A5_A5A5_A5A5, "readback"};
    drive(0, 0, 0, 64'h0);
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      drive(v[i].r, v[i].e, v[i].rd, v[i].d);
      tick();
      drive(0, 0, v[i].rd, 64'h0);
      #1;
      chk({v[i].name, "_t0"}, b0.out, v[i].exp);
      if (v[i].rd) chk({v[i].name, "_t1"}, b1.out, v[i].exp);
    end
    // write 59 over A5A5 with Read high: old value visible before the edge, new after
    drive(0, 1, 1, 64'h59);
    #1;
`ifdef REGISTER_64_BYPASS_EN
    chk("pre_edge_bypass", b0.out, 64'h59);
`else
    chk("pre_edge_old", b0.out, 64'hA5A5_A5A5_A5A5_A5A5);
`endif
    tick();
    drive(0, 0, 1, 64'h0);
    #1;
    chk("post_edge_new", b0.out, 64'h59);
    // Read gating is combinational
    b0.Read = 0; b1.Read = 0;
    #1;
    chk("read_off_zero", b0.out, 64'h0);
    checks++;
    if (b1.out === 64'h59) begin
      failures++;
      $display("FAIL read_off_float actual=%h required=not_%h", b1.out, 64'h59);
    end
    b0.Read = 1; b1.Read = 1;
    #1;
    chk("read_on_t0", b0.out, 64'h59);
    chk("read_on_t1", b1.out, 64'h59);
    // reset to 0, then bypass case from a zero register
    drive(1, 0, 1, 64'h0);
    tick();
    drive(0, 1, 1, 64'hA5A5_A5A5_A5A5_A5A5);
    #1;
`ifdef REGISTER_64_BYPASS_EN
    chk("bypass_a5", b0.out, 64'hA5A5_A5A5_A5A5_A5A5);
`else
    chk("no_bypass_a5", b0.out, 64'h0);
`endif
    tick();
    drive(0, 0, 1, 64'h0);
    #1;
    chk("a5_stored", b1.out, 64'hA5A5_A5A5_A5A5_A5A5);
    // reset with En held keeps bypass off and discards data
    drive(1, 1, 1, 64'h1234);
    #1;
`ifdef REGISTER_64_BYPASS_EN
    chk("rst_blocks_bypass", b0.out, 64'hA5A5_A5A5_A5A5_A5A5);
`else
    chk("rst_pre_edge", b0.out, 64'hA5A5_A5A5_A5A5_A5A5);
`endif
    tick();
    drive(0, 0, 1, 64'h0);
    #1;
    chk("rst_post_edge", b0.out, 64'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
